rhd_convert_sequencer: RTL and testbench
========================================

Name: rhd_convert_sequencer

Overview:
- Command sequencer sitting directly upstream of the 16-bit DDR SPI master that drives the RHD2164.
- Generates chip-select and CONVERT command words for channels 0..NUM_CH-1, plus two flush words.
- Pulses the master's start input and waits for its done.
- Realigns the two-command-latency MISO A/B results to channel numbers and emits one sample pair per channel on a valid strobe.

Parameters:
- NUM_CH, 32: CONVERT commands per frame. Range 1..32; channel field is 5 bits.
- CS_SETUP_CLKS, 4: i_clk cycles o_cs_n is low before o_spi_start. Must be >=1.
- CS_HIGH_CLKS, 8: i_clk cycles o_cs_n is held high between words. Must be >=1.
- FLUSH_CMD, 16'hE800: word sent in the two flush slots (READ reg 40).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_en  in  1  level; run frames continuously while high
- o_spi_din  out  16  command word to SPI master
- o_spi_start  out  1  one-cycle start pulse to SPI master
- i_spi_done  in  1  SPI master done/ready
- i_spi_dout_a  in  16  SPI master result, MISO A (falling-edge sampled)
- i_spi_dout_b  in  16  SPI master result, MISO B (rising-edge sampled)
- o_cs_n  out  1  RHD2164 chip select, active low
- o_sample_valid  out  1  one-cycle strobe; sample outputs valid
- o_sample_a  out  16  channel o_sample_ch result from MISO A
- o_sample_b  out  16  channel o_sample_ch result from MISO B
- o_sample_ch  out  5  channel index of the current sample pair
- o_frame_done  out  1  one-cycle pulse, coincident with the last sample of a frame
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: o_cs_n=1, o_spi_start=0, o_spi_din=0, o_sample_valid=0, o_sample_a/b=0, o_sample_ch=0, o_frame_done=0, o_busy=0. State=IDLE, word index w=0.
- Frame: NUM_CH+2 words. For w<NUM_CH, o_spi_din={2'b00, w[5:0], 8'h00} (CONVERT). For w=NUM_CH and w=NUM_CH+1, o_spi_din=FLUSH_CMD.
- o_spi_din is registered and stable from the SETUP entry through WAIT_DONE.
- States:
  - IDLE: o_cs_n=1. Go to SETUP when i_en=1 and i_spi_done=1. The SPI master's done rises some cycles after its own reset, so do not start before it is high.
  - SETUP: o_cs_n=0. Count CS_SETUP_CLKS cycles, then go to START.
  - START: o_spi_start=1 for exactly this one cycle. Go to ACK.
  - ACK: one cycle; ignore i_spi_done, which is still stale high. Go to WAIT_DONE.
  - WAIT_DONE: hold until i_spi_done=1. On that cycle, register i_spi_dout_a/b into capture regs and set o_cs_n=1. Go to GAP.
  - GAP: o_cs_n=1 for CS_HIGH_CLKS cycles. If w=NUM_CH+1: reset w to 0, then go to SETUP if i_en=1, else IDLE. Otherwise increment w and go to SETUP.
- Result alignment: the response captured at the end of word w belongs to the command of word w-2. For w>=2, on the first GAP cycle assert o_sample_valid=1, o_sample_ch=w-2, o_sample_a/b=captured values.
- Words 0 and 1 produce no sample; their responses belong to the previous frame and are discarded.
- o_frame_done pulses with the sample where o_sample_ch=NUM_CH-1.
- o_sample_a/b/ch hold their value between strobes.
- i_en falling mid-frame: the current frame completes with all NUM_CH samples, then the block returns to IDLE. i_en is sampled only at the frame boundary (end of GAP of w=NUM_CH+1) and in IDLE.
- i_spi_done held low indefinitely: the block stays in WAIT_DONE with o_cs_n=0. No timeout.
- Asynchronous reset mid-word: all outputs return immediately to their reset values, o_cs_n goes high, and the partial frame is abandoned.
- Per-word cycle cost: CS_SETUP_CLKS + 2 + (SPI transfer) + CS_HIGH_CLKS.

Test Plan:
- Reset then i_en=1, NUM_CH=4, SPI model with done after 20 cycles -> o_spi_din sequence 16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hE800, 16'hE800. Exactly one o_spi_start per word.
- SPI model returns dout_a=16'hA000+k, dout_b=16'hB000+k on word k -> samples ch0..3 = (A002,B002)..(A005,B005). o_frame_done coincides with ch=3.
- CS timing -> o_cs_n low exactly CS_SETUP_CLKS=4 cycles before each start pulse, and high for >=8 cycles between words.
- i_en dropped during word 1 -> all 4 samples are still emitted, then IDLE, o_busy=0, no further starts.
- i_spi_done held low 500 cycles in word 2 -> o_cs_n stays 0, no sample strobes. Release -> sequence resumes correctly.
- i_rst asserted during WAIT_DONE -> o_cs_n=1 and o_sample_valid=0 immediately. After release with i_en=1, the frame restarts at 16'h0000.

Source files
------------

// File: rtl/rhd_convert_sequencer.sv
// rtl/rhd_convert_sequencer.sv - RHD2164 CONVERT command sequencer with two-word MISO realignment
module rhd_convert_sequencer #(
    parameter int          NUM_CH        = 32,
    parameter int          CS_SETUP_CLKS = 4,
    parameter int          CS_HIGH_CLKS  = 8,
    parameter logic [15:0] FLUSH_CMD     = 16'hE800
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_spi_din,
    output logic        o_spi_start,
    input  logic        i_spi_done,
    input  logic [15:0] i_spi_dout_a,
    input  logic [15:0] i_spi_dout_b,
    output logic        o_cs_n,
    output logic        o_sample_valid,
    output logic [15:0] o_sample_a,
    output logic [15:0] o_sample_b,
    output logic [4:0]  o_sample_ch,
    output logic        o_frame_done,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_ACK, S_WAIT_DONE, S_GAP
    } state_t;

    localparam logic [5:0]  NUM_W      = 6'(NUM_CH);
    localparam logic [5:0]  LAST_W     = 6'(NUM_CH + 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CLKS - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_HIGH_CLKS - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [5:0]  w, w_nxt;
    logic        load_din;
    logic        capture;
    logic [15:0] din_nxt;
    logic [5:0]  sample_ch_w;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        w_nxt     = w;
        load_din  = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                // done must be high first: the SPI master only reports ready some cycles after its own reset
                if (i_en && i_spi_done) begin
                    state_nxt = S_SETUP;
                    load_din  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            S_START: state_nxt = S_ACK;
            // done is still high from the previous word during this cycle
            S_ACK:   state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (i_spi_done) begin
                    state_nxt = S_GAP;
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (w == LAST_W) begin
                        w_nxt     = '0;
                        state_nxt = i_en ? S_SETUP : S_IDLE;
                        load_din  = i_en;
                    end else begin
                        w_nxt     = w + 6'd1;
                        state_nxt = S_SETUP;
                        load_din  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign din_nxt     = (w_nxt < NUM_W) ? {2'b00, w_nxt, 8'h00} : FLUSH_CMD;
    assign sample_ch_w = w - 6'd2;

    // The response captured at word w answers the command issued at word w-2
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt            <= '0;
            w              <= '0;
            o_spi_din      <= '0;
            o_sample_valid <= 1'b0;
            o_sample_a     <= '0;
            o_sample_b     <= '0;
            o_sample_ch    <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            w              <= w_nxt;
            o_sample_valid <= 1'b0;
            o_frame_done   <= 1'b0;
            if (load_din) begin
                o_spi_din <= din_nxt;
            end
            if (capture && (w >= 6'd2)) begin
                o_sample_valid <= 1'b1;
                o_sample_a     <= i_spi_dout_a;
                o_sample_b     <= i_spi_dout_b;
                o_sample_ch    <= sample_ch_w[4:0];
                o_frame_done   <= (w == LAST_W);
            end
        end
    end

    assign o_cs_n      = !(state == S_SETUP || state == S_START ||
                           state == S_ACK   || state == S_WAIT_DONE);
    assign o_spi_start = (state == S_START);
    assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_rhd_convert_sequencer.sv
// tb/tb_rhd_convert_sequencer.sv - self-checking bench for rhd_convert_sequencer
module tb_rhd_convert_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic [15:0] o_spi_din;
    logic        o_spi_start;
    logic        spi_done;
    logic [15:0] spi_dout_a;
    logic [15:0] spi_dout_b;
    logic        o_cs_n;
    logic        o_sample_valid;
    logic [15:0] o_sample_a;
    logic [15:0] o_sample_b;
    logic [4:0]  o_sample_ch;
    logic        o_frame_done;
    logic        o_busy;

    rhd_convert_sequencer #(
        .NUM_CH(4), .CS_SETUP_CLKS(4), .CS_HIGH_CLKS(8), .FLUSH_CMD(16'hE800)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .o_spi_din(o_spi_din), .o_spi_start(o_spi_start), .i_spi_done(spi_done),
        .i_spi_dout_a(spi_dout_a), .i_spi_dout_b(spi_dout_b), .o_cs_n(o_cs_n),
        .o_sample_valid(o_sample_valid), .o_sample_a(o_sample_a), .o_sample_b(o_sample_b),
        .o_sample_ch(o_sample_ch), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // SPI master model: 20-cycle transfer, done stays stale-high through the cycle after start
    logic [5:0]  spi_cnt;
    logic        stale;
    logic [15:0] k;
    logic        hold;
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            spi_cnt <= '0; stale <= 1'b0; k <= '0; spi_dout_a <= '0; spi_dout_b <= '0;
        end else if (o_spi_start) begin
            spi_cnt <= 6'd20; stale <= 1'b1;
        end else begin
            stale <= 1'b0;
            if (spi_cnt != 0 && !(spi_cnt == 1 && hold)) begin
                spi_cnt <= spi_cnt - 6'd1;
                if (spi_cnt == 1) begin
                    spi_dout_a <= 16'hA000 + k;
                    spi_dout_b <= 16'hB000 + k;
                    k <= k + 16'd1;
                end
            end
        end
    end
    assign spi_done = (spi_cnt == 0) || stale;

    typedef struct {
        logic [15:0] din;
        logic        has_sample;
        logic [4:0]  ch;
    } word_t;

    typedef struct packed {
        logic [4:0]  ch;
        logic [15:0] a;
        logic [15:0] b;
        logic        fd;
    } samp_t;

    word_t       frame_tbl[6];
    logic [15:0] din_q[$];
    samp_t       samp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_start  = 0;
    int          lo_run = 0, hi_run = 0;
    logic        prev_cs_n = 1'b1;
    logic        word_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int f);
        samp_t s;
        for (int i = 0; i < 6; i++) begin
            din_q.push_back(frame_tbl[i].din);
            if (frame_tbl[i].has_sample) begin
                s.ch = frame_tbl[i].ch;
                s.a  = 16'hA000 + 16'(6 * f + i);
                s.b  = 16'hB000 + 16'(6 * f + i);
                s.fd = (frame_tbl[i].ch == 5'd3);
                samp_q.push_back(s);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            lo_run = 0; hi_run = 0; word_seen = 1'b0; prev_cs_n = 1'b1;
        end else begin
            if (o_spi_start) begin
                n_start++;
                if (din_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_start: got start din=%h expected none", o_spi_din);
                end else begin
                    chk("spi_din", {16'h0, o_spi_din}, {16'h0, din_q.pop_front()});
                end
                chk("cs_setup_clks", lo_run, 4);
                word_seen = 1'b1;
            end
            if (o_sample_valid) begin
                if (samp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_sample: got ch=%0d expected none", o_sample_ch);
                end else begin
                    samp_t s;
                    s = samp_q.pop_front();
                    chk("sample_ch", {27'h0, o_sample_ch}, {27'h0, s.ch});
                    chk("sample_a", {16'h0, o_sample_a}, {16'h0, s.a});
                    chk("sample_b", {16'h0, o_sample_b}, {16'h0, s.b});
                    chk("frame_done", {31'h0, o_frame_done}, {31'h0, s.fd});
                end
            end else if (o_frame_done) begin
                chk("frame_done_without_valid", {31'h0, o_frame_done}, 32'h0);
            end
            if (!o_cs_n && prev_cs_n && word_seen)
                chk("cs_high_gap_ge8", {31'h0, hi_run >= 8}, 32'h1);
            if (!o_busy) word_seen = 1'b0;
            if (!o_cs_n) begin lo_run++; hi_run = 0; end
            else begin hi_run++; lo_run = 0; end
            prev_cs_n = o_cs_n;
        end
    end

    task automatic wait_starts(input int n);
        int t = 0;
        while (n_start < n && t < 5000) begin @(negedge i_clk); t++; end
        chk("wait_starts", {31'h0, n_start >= n}, 32'h1);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge i_clk);
        while (o_busy && t < 5000) begin @(negedge i_clk); t++; end
        chk("busy_after_frame", {31'h0, o_busy}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge i_clk); i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    initial begin
        int base;
        int bad;
        frame_tbl[0] = '{16'h0000, 1'b0, 5'd0};
        frame_tbl[1] = '{16'h0100, 1'b0, 5'd0};
        frame_tbl[2] = '{16'h0200, 1'b1, 5'd0};
        frame_tbl[3] = '{16'h0300, 1'b1, 5'd1};
        frame_tbl[4] = '{16'hE800, 1'b1, 5'd2};
        frame_tbl[5] = '{16'hE800, 1'b1, 5'd3};
        i_rst = 1'b0; i_en = 1'b0; hold = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_cs_n", {31'h0, o_cs_n}, 32'h1);
        chk("rst_start", {31'h0, o_spi_start}, 32'h0);
        chk("rst_din", {16'h0, o_spi_din}, 32'h0);
        chk("rst_valid", {31'h0, o_sample_valid}, 32'h0);
        chk("rst_sample_ab", {o_sample_a, o_sample_b}, 32'h0);
        chk("rst_ch_fd_busy", {25'h0, o_sample_ch, o_frame_done, o_busy}, 32'h0);
        i_rst = 1'b1;
        repeat (5) @(negedge i_clk);
        chk("idle_no_en_busy", {31'h0, o_busy}, 32'h0);

        // two frames, i_en dropped during word 1 of the second
        push_frame(0); push_frame(1);
        i_en = 1'b1;
        wait_starts(8);
        i_en = 1'b0;
        wait_idle();
        repeat (200) @(negedge i_clk);
        chk("starts_two_frames", n_start, 12);
        chk("queues_empty_1", din_q.size() + samp_q.size(), 0);

        // done held low 500 cycles during word 2
        do_reset();
        base = n_start;
        push_frame(0);
        i_en = 1'b1;
        wait_starts(base + 3);
        hold = 1'b1; i_en = 1'b0;
        bad = 0;
        repeat (500) begin
            @(negedge i_clk);
            if (o_cs_n !== 1'b0 || o_sample_valid !== 1'b0) bad++;
        end
        chk("hold_cs_low_no_strobe", bad, 0);
        hold = 1'b0;
        wait_idle();
        chk("queues_empty_2", din_q.size() + samp_q.size(), 0);

        // asynchronous reset during WAIT_DONE of word 2
        do_reset();
        base = n_start;
        push_frame(0);
        i_en = 1'b1;
        wait_starts(base + 3);
        repeat (5) @(posedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        chk("async_rst_cs_n", {31'h0, o_cs_n}, 32'h1);
        chk("async_rst_valid_busy", {30'h0, o_sample_valid, o_busy}, 32'h0);
        chk("async_rst_din", {16'h0, o_spi_din}, 32'h0);
        din_q.delete(); samp_q.delete();
        repeat (2) @(negedge i_clk);
        push_frame(0);
        base = n_start;
        i_rst = 1'b1;
        wait_starts(base + 2);
        i_en = 1'b0;
        wait_idle();
        chk("queues_empty_3", din_q.size() + samp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
